// File: rtl/step_pkg.sv
// Shared types and constants for the step_input_logic front end.
//   step_state_t : instruction sequencer states (IDLE, RUN, FIN)
//   T0..T3       : timestep encodings driven on TIME
package step_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } step_state_t;

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

endpackage

// File: rtl/step_input_logic_key_debouncer.sv
// key_debouncer: synchronises and debounces one raw active-low push-key.
//   CLK     in  system clock
//   RST     in  synchronous active-high reset
//   KEY_N   in  raw key, active-low, asynchronous, bouncy
//   LEVEL_N out debounced (stable) key level, 1 = released
//   PRESS   out one-cycle registered pulse when LEVEL_N falls 1->0
// A new synced level must persist for DEBOUNCE_CYCLES consecutive cycles
// before LEVEL_N takes it; any return to the stable level restarts the count.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLK,
  input  logic RST,
  input  logic KEY_N,
  output logic LEVEL_N,
  output logic PRESS
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_1  <= 1'b1;
      sync_2  <= 1'b1;
      LEVEL_N <= 1'b1;
      cnt     <= '0;
      PRESS   <= 1'b0;
    end else begin
      sync_1 <= KEY_N;
      sync_2 <= sync_1;
      PRESS  <= 1'b0;
      if (sync_2 == LEVEL_N) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        LEVEL_N <= sync_2;
        cnt     <= '0;
        // Only the released->pressed edge is an event; release is silent.
        PRESS   <= ~sync_2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/step_input_logic.sv
// step_input_logic: debounces EXEC/PEEK keys and sequences instruction timesteps.
//   CLK        in   system clock
//   RST        in   synchronous active-high reset
//   KEY_EXEC   in   raw EXEC key, active-low
//   KEY_PEEK   in   raw PEEK key, active-low
//   LAST_STEP  in   [1:0] final timestep of the current instruction
//   TIME       out  [1:0] current timestep
//   DONE       out  instruction finished
//   PEEKb      out  1 = display BUS instead of REG
//   STEP       out  one-cycle pulse when a timestep is entered/advanced
//   START      out  one-cycle pulse when a new instruction begins at T0
// Build option: define PEEK_TOGGLE_EN to make each PEEK press toggle PEEKb;
// otherwise PEEKb mirrors the debounced PEEK key (high while held).
module step_input_logic
  import step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       KEY_EXEC,
  input  logic       KEY_PEEK,
  input  logic [1:0] LAST_STEP,
  output logic [1:0] TIME,
  output logic       DONE,
  output logic       PEEKb,
  output logic       STEP,
  output logic       START
);

  logic exec_level_unused;
  logic exec_press;
  logic peek_level;
  logic peek_press;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exec_deb (
    .CLK     (CLK),
    .RST     (RST),
    .KEY_N   (KEY_EXEC),
    .LEVEL_N (exec_level_unused),
    .PRESS   (exec_press)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_peek_deb (
    .CLK     (CLK),
    .RST     (RST),
    .KEY_N   (KEY_PEEK),
    .LEVEL_N (peek_level),
    .PRESS   (peek_press)
  );

  step_state_t state, state_next;
  logic [1:0]  time_next;
  logic        done_next;
  logic        step_next;
  logic        start_next;

  // NOTE: reset is sampled on the clock edge here, so it never appears in
  // the sensitivity list.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    state_next = state;
    if (exec_press) begin
      case (state)
        IDLE:    state_next = RUN;
        RUN:     if (TIME >= LAST_STEP) state_next = FIN;
        FIN:     state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // LAST_STEP only matters inside this press-qualified branch, so changes
  // between presses can never move TIME.
  always_comb begin
    time_next  = TIME;
    done_next  = DONE;
    step_next  = 1'b0;
    start_next = 1'b0;
    if (exec_press) begin
      case (state)
        IDLE, FIN: begin
          time_next  = T0;
          done_next  = 1'b0;
          step_next  = 1'b1;
          start_next = 1'b1;
        end
        RUN: begin
          // >= so a LAST_STEP lowered below TIME still finishes; TIME never wraps.
          if (TIME >= LAST_STEP) begin
            done_next = 1'b1;
          end else begin
            time_next = TIME + 2'd1;
            step_next = 1'b1;
          end
        end
        default: begin
          time_next = T0;
          done_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      TIME  <= T0;
      DONE  <= 1'b0;
      STEP  <= 1'b0;
      START <= 1'b0;
    end else begin
      TIME  <= time_next;
      DONE  <= done_next;
      STEP  <= step_next;
      START <= start_next;
    end
  end

`ifdef PEEK_TOGGLE_EN
  logic peek_level_unused;
  assign peek_level_unused = peek_level;

  always_ff @(posedge CLK) begin
    if (RST)             PEEKb <= 1'b0;
    else if (peek_press) PEEKb <= ~PEEKb;
  end
`else
  logic peek_press_unused;
  assign peek_press_unused = peek_press;

  always_ff @(posedge CLK) begin
    if (RST) PEEKb <= 1'b0;
    else     PEEKb <= ~peek_level;
  end
`endif

endmodule

// File: tb/tb_step_input_logic.sv
// Directed self-checking bench for step_input_logic with DEBOUNCE_CYCLES=4.
// Expected latency from a clean raw fall to updated outputs is 4+3 = 7 cycles.
module tb_step_input_logic;
  import step_pkg::*;

  localparam int DC  = 4;
  localparam int LAT = DC + 3;

  logic       CLK = 1'b0;
  logic       RST;
  logic       KEY_EXEC;
  logic       KEY_PEEK;
  logic [1:0] LAST_STEP;
  logic [1:0] TIME;
  logic       DONE;
  logic       PEEKb;
  logic       STEP;
  logic       START;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  step_input_logic #(.DEBOUNCE_CYCLES(DC)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .KEY_EXEC  (KEY_EXEC),
    .KEY_PEEK  (KEY_PEEK),
    .LAST_STEP (LAST_STEP),
    .TIME      (TIME),
    .DONE      (DONE),
    .PEEKb     (PEEKb),
    .STEP      (STEP),
    .START     (START)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Clean press: outputs must still be idle one cycle before the latency.
  task automatic press_exec(input string tag);
    KEY_EXEC = 1'b0;
    repeat (LAT - 1) tick();
    check({tag, "_step_not_early"}, int'(STEP), 0);
    tick();
  endtask

  task automatic release_exec(input string tag);
    tick();
    check({tag, "_strobe_one_cycle"}, int'(STEP | START), 0);
    KEY_EXEC = 1'b1;
    repeat (LAT + 3) tick();
  endtask

  int exp_time  [5] = '{0, 1, 2, 2, 0};
  int exp_done  [5] = '{0, 0, 0, 1, 0};
  int exp_step  [5] = '{1, 1, 1, 0, 1};
  int exp_start [5] = '{1, 0, 0, 0, 1};

  initial begin
    int steps;
    int step_at;

    // 1. Reset with keys low, then release keys and reset.
    RST = 1'b1; KEY_EXEC = 1'b0; KEY_PEEK = 1'b0; LAST_STEP = 2'd0;
    repeat (2) tick();
    check("rst_time",  int'(TIME),  0);
    check("rst_done",  int'(DONE),  0);
    check("rst_peekb", int'(PEEKb), 0);
    check("rst_step",  int'(STEP),  0);
    check("rst_start", int'(START), 0);
    check("rst_state", int'(dut.state), int'(IDLE));
    KEY_EXEC = 1'b1; KEY_PEEK = 1'b1;
    RST = 1'b0;
    steps = 0;
    repeat (20) begin tick(); steps += int'(STEP); end
    check("no_step_after_reset", steps, 0);

    // 2. LAST_STEP=2, five clean presses.
    LAST_STEP = 2'd2;
    for (int i = 0; i < 5; i++) begin
      press_exec($sformatf("t2_p%0d", i));
      check($sformatf("t2_p%0d_time",  i), int'(TIME),  exp_time[i]);
      check($sformatf("t2_p%0d_done",  i), int'(DONE),  exp_done[i]);
      check($sformatf("t2_p%0d_step",  i), int'(STEP),  exp_step[i]);
      check($sformatf("t2_p%0d_start", i), int'(START), exp_start[i]);
      release_exec($sformatf("t2_p%0d", i));
    end

    // 3. Bounce 2-cycle pulses for 20 cycles, then a solid hold.
    steps = 0; step_at = -1;
    for (int i = 0; i < 10; i++) begin
      KEY_EXEC = (i % 2 == 1);
      repeat (2) begin tick(); steps += int'(STEP); end
    end
    KEY_EXEC = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (STEP) begin steps++; step_at = k; end
    end
    check("bounce_single_step", steps, 1);
    check("bounce_latency", step_at, LAT);
    check("bounce_time", int'(TIME), 1);
    KEY_EXEC = 1'b1;
    repeat (LAT + 3) tick();

    // 4. LAST_STEP below TIME, then LAST_STEP=0, then change while in FIN.
    LAST_STEP = 2'd0;
    press_exec("t4_below");
    check("t4_below_done", int'(DONE), 1);
    check("t4_below_time", int'(TIME), 1);
    check("t4_below_step", int'(STEP), 0);
    release_exec("t4_below");
    press_exec("t4_enter");
    check("t4_enter_time",  int'(TIME),  0);
    check("t4_enter_done",  int'(DONE),  0);
    check("t4_enter_start", int'(START), 1);
    release_exec("t4_enter");
    press_exec("t4_fin");
    check("t4_fin_done", int'(DONE), 1);
    check("t4_fin_time", int'(TIME), 0);
    release_exec("t4_fin");
    LAST_STEP = 2'd3;
    repeat (10) tick();
    check("t4_ls_change_time", int'(TIME), 0);
    check("t4_ls_change_done", int'(DONE), 1);
    press_exec("t4_restart");
    check("t4_restart_time",  int'(TIME),  0);
    check("t4_restart_done",  int'(DONE),  0);
    check("t4_restart_start", int'(START), 1);
    release_exec("t4_restart");
    press_exec("t4_adv");
    check("t4_adv_time", int'(TIME), 1);
    release_exec("t4_adv");

    // 5. PEEK behaviour.
    KEY_PEEK = 1'b0;
    repeat (LAT - 1) tick();
    check("peek_rise_early", int'(PEEKb), 0);
    tick();
    check("peek_rise", int'(PEEKb), 1);
    repeat (10) tick();
    check("peek_hold", int'(PEEKb), 1);
    KEY_PEEK = 1'b1;
`ifdef PEEK_TOGGLE_EN
    repeat (20) tick();
    check("peek_toggle_held", int'(PEEKb), 1);
    KEY_PEEK = 1'b0;
    repeat (LAT) tick();
    check("peek_toggle_off", int'(PEEKb), 0);
    KEY_PEEK = 1'b1;
    repeat (LAT + 3) tick();
`else
    repeat (LAT - 1) tick();
    check("peek_fall_early", int'(PEEKb), 1);
    tick();
    check("peek_fall", int'(PEEKb), 0);
    repeat (3) tick();
`endif
    KEY_EXEC = 1'b0; KEY_PEEK = 1'b0;
    repeat (LAT) tick();
    check("simul_step",  int'(STEP),  1);
    check("simul_time",  int'(TIME),  2);
    check("simul_peekb", int'(PEEKb), 1);
    KEY_EXEC = 1'b1; KEY_PEEK = 1'b1;
    repeat (LAT + 3) tick();

    // 6. Reset during RUN T1 with an EXEC debounce pending.
    RST = 1'b1;
    repeat (2) tick();
    RST = 1'b0;
    tick();
    LAST_STEP = 2'd3;
    press_exec("t6_p0");
    release_exec("t6_p0");
    press_exec("t6_p1");
    check("t6_pre_time",  int'(TIME), 1);
    check("t6_pre_state", int'(dut.state), int'(RUN));
    release_exec("t6_p1");
    KEY_EXEC = 1'b0;
    repeat (3) tick();
    RST = 1'b1;
    tick();
    KEY_EXEC = 1'b1;
    tick();
    check("t6_rst_time",  int'(TIME), 0);
    check("t6_rst_state", int'(dut.state), int'(IDLE));
    RST = 1'b0;
    steps = 0;
    repeat (20) begin tick(); steps += int'(STEP); end
    check("t6_no_step", steps, 0);
    check("t6_time_after", int'(TIME), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
